ioctl_download_source: RTL and testbench



---
 rtl/ioctl_download_pkg.sv | 21 ++
 rtl/download_gap_timer.sv | 29 ++
 rtl/ioctl_download_source.sv | 168 ++++++++++++++++
 tb/tb_ioctl_download_source.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_download_pkg.sv
// Shared types and defaults for the ROM download initiator (ioctl_download_source).
package ioctl_download_pkg;

  localparam int DEF_ADDR_W       = 25;
  localparam int DEF_LEN_W        = 24;
  localparam int DEF_SETUP_CYCLES = 4;
  localparam int DEF_WR_GAP       = 2;
  localparam int ADDR_STEP        = 2;
  localparam int TMR_W            = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    WRITE,
    GAP,
    HOLD,
    FINISH
  } state_e;

endpackage

// File: rtl/download_gap_timer.sv
// Loadable down-counter shared by the SETUP hold-off and the post-write gap.
module download_gap_timer
  import ioctl_download_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ioctl_download_source.sv
// Initiator side of the ROM download bus: streams 16-bit words from a valid/ready source
// into ioctl_*. Optional running checksum output under `define DOWNLOAD_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start; index/dout hold last values
// SETUP  | ioctl_download high, index stable, SETUP_CYCLES before first word
// FETCH  | src_ready high, waiting for a source word
// WRITE  | single-cycle ioctl_wr with addr/dout stable
// GAP    | WR_GAP idle cycles before ioctl_wait is trusted
// HOLD   | waiting for ioctl_wait low, then next word or finish
// FINISH | ioctl_download low, done pulse
module ioctl_download_source
  import ioctl_download_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int WR_GAP       = DEF_WR_GAP
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [15:0]       src_data,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_dout,
  output logic              ioctl_wr,
  input  logic              ioctl_wait,
  output logic              busy,
`ifdef DOWNLOAD_CHECKSUM_EN
  output logic              done,
  output logic [15:0]       checksum
`else
  output logic              done
`endif
);

  state_e             state_q, state_d;
  logic               abort_q, abort_d;
  logic [LEN_W-1:0]   len_q, cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         index_q;
  logic [15:0]        dout_q;
  logic               tmr_load, tmr_en, tmr_exp;
  logic [TMR_W-1:0]   tmr_val;
  logic               abort_pend, last_word, start_go, addr_step;

  // A same-cycle abort counts as pending so no word is taken in the cycle it arrives.
  assign abort_pend = abort_q | abort;
  assign last_word  = (cnt_q == len_q);
  assign start_go   = (state_q == IDLE) && start && (length != '0);
  assign addr_step  = (state_q == HOLD) && !ioctl_wait && !(last_word || abort_pend);

  download_gap_timer #(.W(TMR_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(SETUP_CYCLES - 1);
          end else begin
            state_d = FINISH;
          end
        end
      end
      SETUP: begin
        tmr_en = 1'b1;
        if (abort_pend)   state_d = FINISH;
        else if (tmr_exp) state_d = FETCH;
      end
      FETCH: begin
        if (abort_pend)     state_d = FINISH;
        else if (src_valid) state_d = WRITE;
      end
      WRITE: begin
        state_d  = GAP;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(WR_GAP - 1);
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tmr_exp) state_d = HOLD;
      end
      HOLD: begin
        if (!ioctl_wait) state_d = (last_word || abort_pend) ? FINISH : FETCH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abort_d = abort_q;
    if (state_q == FINISH)                abort_d = 1'b0;
    else if (state_q != IDLE && abort)    abort_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      index_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (start_go) begin
        index_q <= index;
        len_q   <= length;
        cnt_q   <= '0;
        addr_q  <= '0;
      end
      if (src_ready && src_valid) dout_q <= src_data;
      if (state_q == WRITE)       cnt_q  <= cnt_q + 1'b1;
      if (addr_step)              addr_q <= addr_q + ADDR_W'(ADDR_STEP);
    end
  end

`ifdef DOWNLOAD_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      csum_q <= '0;
    end else if (state_q == WRITE) begin
      csum_q <= csum_q + dout_q;
    end
  end

  assign checksum = csum_q;
`endif

  assign src_ready      = (state_q == FETCH) && !abort_pend;
  assign ioctl_download = (state_q == SETUP) || (state_q == FETCH) || (state_q == WRITE) ||
                          (state_q == GAP)   || (state_q == HOLD);
  assign ioctl_wr       = (state_q == WRITE);
  assign ioctl_index    = index_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);

endmodule

// File: tb/tb_ioctl_download_source.sv
// Directed scoreboard bench for ioctl_download_source (checksum checks when DOWNLOAD_CHECKSUM_EN is defined).
module tb_ioctl_download_source;

  localparam int ADDR_W = 25;
  localparam int LEN_W  = 24;
  localparam int SETUP  = 4;
  localparam int GAPN   = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        index;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              src_valid;
  logic              src_ready;
  logic [15:0]       src_data;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wr;
  logic              ioctl_wait;
  logic              busy;
  logic              done;
`ifdef DOWNLOAD_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  logic [15:0] src_mem [0:63];
  int          src_idx = 0;
  assign src_data = src_mem[src_idx[5:0]];

  exp_t        exp_q[$];
  int          wr_at[$];
  logic [7:0]  exp_idx = '0;
  int          n_asserts = 0, n_fail = 0;
  int          cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_dl_hi = 0;
  int          start_cyc = 0;
  bit          prev_wr = 1'b0, dl_seen = 1'b0;

  always #5 clock = ~clock;

  ioctl_download_source #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SETUP_CYCLES(SETUP), .WR_GAP(GAPN)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .index          (index),
    .length         (length),
    .abort          (abort),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_data       (src_data),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .busy           (busy),
`ifdef DOWNLOAD_CHECKSUM_EN
    .checksum       (checksum),
`endif
    .done           (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // One clock: note the handshake that the coming edge will see, then observe at the negedge.
  task automatic tick();
    bit hs;
    exp_t e;
    #1;
    hs = src_valid && src_ready;
    @(negedge clock);
    cyc++;
    if (hs) src_idx++;
    if (ioctl_wr === 1'b1) begin
      chk("wr_wait_low", {31'd0, ioctl_wait}, 0);
      chk("wr_not_back_to_back", {31'd0, prev_wr}, 0);
      chk("wr_expected_pending", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {7'd0, ioctl_addr}, {7'd0, e.addr});
        chk("wr_data", {16'd0, ioctl_dout}, {16'd0, e.data});
        chk("wr_index", {24'd0, ioctl_index}, {24'd0, exp_idx});
      end
      wr_cnt++;
      wr_at.push_back(cyc);
    end
    prev_wr = ioctl_wr;
    if (ioctl_download) begin dl_seen = 1'b1; last_dl_hi = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic load_words(input int n, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < n; i++) src_mem[(src_idx + i) % 64] = w[i];
  endtask

  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{addr: ADDR_W'(2 * i), data: src_mem[(src_idx + i) % 64]});
  endtask

  task automatic kick(input int len, input logic [7:0] idx);
    index     = idx;
    length    = LEN_W'(len);
    exp_idx   = idx;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (wr_cnt < target && n < 200) begin tick(); n++; end
    chk(tag, wr_cnt, target);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 200) begin tick(); n++; end
    chk(tag, done_cnt, target);
  endtask

  initial begin
    int base, rel, w1;
    for (int i = 0; i < 64; i++) src_mem[i] = 16'h0;
    reset_n = 1'b0; start = 1'b0; index = '0; length = '0; abort = 1'b0;
    src_valid = 1'b1; ioctl_wait = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_download", {31'd0, ioctl_download}, 0);
    chk("rst_wr", {31'd0, ioctl_wr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_addr", {7'd0, ioctl_addr}, 0);
    chk("rst_index", {24'd0, ioctl_index}, 0);

    // Basic three-word transfer
    base = wr_cnt;
    load_words(3, 16'h1111, 16'h2222, 16'h3333, 16'h0);
    expect_words(3);
    kick(3, 8'h01);
    wait_wr(base + 3, "t1_three_writes");
    chk("t1_first_latency", wr_at[base] - start_cyc, SETUP + 2);
    chk("t1_spacing_1_2", wr_at[base + 1] - wr_at[base], GAPN + 3);
    chk("t1_spacing_2_3", wr_at[base + 2] - wr_at[base + 1], GAPN + 3);
    wait_done(1, "t1_done");
    chk("t1_done_after_download_fall", done_cyc - last_dl_hi, 1);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 0);
    chk("t1_idle_index_held", {24'd0, ioctl_index}, 32'h01);
    chk("t1_idle_dout_held", {16'd0, ioctl_dout}, 32'h3333);

    // Wait back-pressure after second write; start while busy is ignored
    base = wr_cnt;
    load_words(3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0);
    expect_words(3);
    kick(3, 8'h22);
    wait_wr(base + 1, "t2_first_write");
    index = 8'h99; length = LEN_W'(7); start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(base + 2, "t2_second_write");
    ioctl_wait = 1'b1;
    repeat (10) tick();
    chk("t2_no_wr_during_wait", wr_cnt, base + 2);
    ioctl_wait = 1'b0;
    rel = cyc;
    wait_wr(base + 3, "t2_third_write");
    chk("t2_third_after_release", wr_at[base + 2] - rel, 2);
    wait_done(2, "t2_done");
    repeat (3) tick();
    chk("t2_total_writes", wr_cnt, base + 3);
    chk("t2_scoreboard_empty", exp_q.size(), 0);

    // Source starvation before word 2
    base = wr_cnt;
    load_words(2, 16'hA5A5, 16'h5A5A, 16'h0, 16'h0);
    expect_words(2);
    kick(2, 8'h03);
    wait_wr(base + 1, "t3_first_write");
    src_valid = 1'b0;
    repeat (5) tick();
    chk("t3_ready_while_starved", {31'd0, src_ready}, 1);
    chk("t3_no_wr_while_starved", wr_cnt, base + 1);
    src_valid = 1'b1;
    rel = cyc;
    wait_wr(base + 2, "t3_second_write");
    chk("t3_write_after_valid", wr_at[base + 1] - rel, 1);
    wait_done(3, "t3_done");
    tick();

    // Zero length
    base = wr_cnt;
    dl_seen = 1'b0;
    kick(0, 8'h04);
    wait_done(4, "t4_done");
    chk("t4_done_latency", done_cyc - start_cyc, 1);
    repeat (3) tick();
    chk("t4_single_done", done_cnt, 4);
    chk("t4_no_download", {31'd0, dl_seen}, 0);
    chk("t4_no_writes", wr_cnt, base);

    // Abort during the gap after word 1 of 4, finish only once wait drops
    base = wr_cnt;
    load_words(4, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    expect_words(1);
    kick(4, 8'h05);
    wait_wr(base + 1, "t5_first_write");
    tick();
    abort = 1'b1; ioctl_wait = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("t5_no_done_while_wait", done_cnt, 4);
    ioctl_wait = 1'b0;
    rel = cyc;
    wait_done(5, "t5_done");
    chk("t5_finish_after_wait", done_cyc - rel, 1);
    repeat (3) tick();
    chk("t5_one_write", wr_cnt, base + 1);

    // Reset mid-HOLD, then a fresh one-word transfer
    load_words(2, 16'h7777, 16'h8888, 16'h0, 16'h0);
    expect_words(2);
    kick(2, 8'h06);
    wait_wr(wr_cnt + 1, "t6_first_write");
    ioctl_wait = 1'b1;
    repeat (4) tick();
    chk("t6_busy_in_hold", {31'd0, busy}, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_download", {31'd0, ioctl_download}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_addr", {7'd0, ioctl_addr}, 0);
    chk("t6_rst_dout", {16'd0, ioctl_dout}, 0);
    chk("t6_rst_index", {24'd0, ioctl_index}, 0);
    chk("t6_rst_ready", {31'd0, src_ready}, 0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1; ioctl_wait = 1'b0;
    tick();
    w1 = wr_cnt;
    load_words(1, 16'h4242, 16'h0, 16'h0, 16'h0);
    expect_words(1);
    kick(1, 8'h07);
    wait_done(6, "t6_done");
    chk("t6_one_write", wr_cnt, w1 + 1);
    chk("t6_scoreboard_empty", exp_q.size(), 0);

`ifdef DOWNLOAD_CHECKSUM_EN
    tick();
    load_words(2, 16'hFFFF, 16'h0002, 16'h0, 16'h0);
    expect_words(2);
    kick(2, 8'h08);
    wait_done(7, "t7_done");
    chk("t7_checksum", {16'd0, checksum}, 32'h0001);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
